// File: rtl/complex_mult_pipe.sv
// -----------------------------------------------------------------------------
// complex_mult_pipe
//
// Pipelined signed complex multiplier with valid/ready handshakes on both
// sides. Each accepted sample produces P = A*B, or P = A*conj(B) when InConj
// is set. The selection is captured with the operands. Downstream
// backpressure is absorbed by a three-stage elastic pipeline. A stage holds
// its contents while the stage below it cannot accept. Empty stages
// (bubbles) are refilled immediately, so results leave in input order.
//
//   S1 : registers operands {ReA, ImA}, {ReB, ImB} and the conj flag
//   S2 : registers the four W x W signed products ac, bd, ad, bc
//   S3 : registers the Re/Im sums (2W+1 bits, optionally rescaled/saturated)
//
// Optional feature macro: CMULT_SAT_EN
//   undefined : OUT_W = 2W+1. The full-precision sums are output.
//   defined   : OUT_W = W. Each sum x is rescaled by Q(W-1) as
//               (x + 2^(W-2)) >>> (W-1), which rounds half up. The result
//               is then saturated to [-2^(W-1), 2^(W-1)-1]. This is done
//               inside S3, so the latency does not change.
//
// Ports
//   Clk       in   1        rising-edge clock
//   Reset_n   in   1        asynchronous active-low reset; flushes the pipe
//   InValid   in   1        input sample valid
//   InReady   out  1        block accepts the sample this cycle
//   InA       in   2W       operand A = {ReA, ImA}, two's complement
//   InB       in   2W       operand B = {ReB, ImB}, two's complement
//   InConj    in   1        1: multiply by conj(B)
//   OutValid  out  1        result valid
//   OutReady  in   1        downstream accepts the result this cycle
//   OutP      out  2*OUT_W  result {ReP, ImP}, signed; reads 0 while OutValid=0
// -----------------------------------------------------------------------------
module complex_mult_pipe #(
    parameter  int W     = 8,
`ifdef CMULT_SAT_EN
    localparam int OUT_W = W
`else
    localparam int OUT_W = 2 * W + 1
`endif
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [2*W-1:0]       InA,
    input  logic [2*W-1:0]       InB,
    input  logic                 InConj,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [2*OUT_W-1:0]   OutP
);

    localparam int PW = 2 * W;      // product width
    localparam int SW = 2 * W + 1;  // full-precision sum width

    // Handshake / advance terms
    logic adv1;
    logic adv2;
    logic adv3;

    logic vld_p1_q;
    logic vld_p2_q;
    logic vld_p3_q;

    // Stage 1 state
    logic signed [W-1:0]     a_re_p1_d, a_im_p1_d, b_re_p1_d, b_im_p1_d;
    logic signed [W-1:0]     a_re_p1_q, a_im_p1_q, b_re_p1_q, b_im_p1_q;
    logic                    conj_p1_q;

    // Stage 2 state
    logic signed [PW-1:0]    ac_p2_d, bd_p2_d, ad_p2_d, bc_p2_d;
    logic signed [PW-1:0]    ac_p2_q, bd_p2_q, ad_p2_q, bc_p2_q;
    logic                    conj_p2_q;

    // Stage 3 state
    logic signed [SW-1:0]    ac_x, bd_x, ad_x, bc_x;
    logic signed [SW-1:0]    re_sum, im_sum;
    logic signed [OUT_W-1:0] re_p3_d, im_p3_d;
    logic signed [OUT_W-1:0] re_p3_q, im_p3_q;

`ifdef CMULT_SAT_EN
    localparam logic signed [SW-1:0] RND_BIAS = SW'(1) <<< (W - 2);
    localparam logic signed [SW-1:0] SAT_HI   = SW'(2 ** (W - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO   = SW'(-(2 ** (W - 1)));

    // Q(W-1) rescale with round-half-up. The bias cannot overflow SW bits:
    // |x| <= 2^(2W-1) and the bias is only 2^(W-2).
    function automatic logic signed [SW-1:0] round_q(input logic signed [SW-1:0] x);
        return (x + RND_BIAS) >>> (W - 1);
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] r);
        if (r > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (r < SAT_LO) begin
            return SAT_LO[W-1:0];
        end
        return r[W-1:0];
    endfunction
`endif

    // Elastic advance chain. A stage may load when it is empty, or when the
    // stage below it is advancing. InReady is therefore combinational from
    // OutReady, and bubbles collapse.
    assign adv3    = !vld_p3_q || OutReady;
    assign adv2    = !vld_p2_q || adv3;
    assign adv1    = !vld_p1_q || adv2;
    assign InReady = adv1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            if (adv1) vld_p1_q <= InValid;
            if (adv2) vld_p2_q <= vld_p1_q;
            if (adv3) vld_p3_q <= vld_p2_q;
        end
    end

    // ---- input -> S1 : operand capture --------------------------------------
    assign a_re_p1_d = InA[2*W-1:W];
    assign a_im_p1_d = InA[W-1:0];
    assign b_re_p1_d = InB[2*W-1:W];
    assign b_im_p1_d = InB[W-1:0];

    always_ff @(posedge Clk) begin
        if (adv1 && InValid) begin
            a_re_p1_q <= a_re_p1_d;
            a_im_p1_q <= a_im_p1_d;
            b_re_p1_q <= b_re_p1_d;
            b_im_p1_q <= b_im_p1_d;
            conj_p1_q <= InConj;
        end
    end

    // ---- S1 -> S2 : four partial products -----------------------------------
    // Operands are sign-extended to the product width before multiplying.
    // This makes the product context explicit. (-2^(W-1))^2 = 2^(2W-2)
    // still fits in a 2W-bit signed value.
    assign ac_p2_d = PW'(a_re_p1_q) * PW'(b_re_p1_q);
    assign bd_p2_d = PW'(a_im_p1_q) * PW'(b_im_p1_q);
    assign ad_p2_d = PW'(a_re_p1_q) * PW'(b_im_p1_q);
    assign bc_p2_d = PW'(a_im_p1_q) * PW'(b_re_p1_q);

    always_ff @(posedge Clk) begin
        if (adv2 && vld_p1_q) begin
            ac_p2_q   <= ac_p2_d;
            bd_p2_q   <= bd_p2_d;
            ad_p2_q   <= ad_p2_d;
            bc_p2_q   <= bc_p2_d;
            conj_p2_q <= conj_p1_q;
        end
    end

    // ---- S2 -> S3 : Re/Im sums (+ optional rescale/saturate) ----------------
    // Products are widened by one bit before the add. The sum of two
    // most-negative squares is 2^(2W-1), which does not fit in 2W bits.
    assign ac_x = SW'(ac_p2_q);
    assign bd_x = SW'(bd_p2_q);
    assign ad_x = SW'(ad_p2_q);
    assign bc_x = SW'(bc_p2_q);

    always_comb begin
        re_sum = '0;
        im_sum = '0;
        if (conj_p2_q) begin
            re_sum = ac_x + bd_x;
            im_sum = bc_x - ad_x;
        end else begin
            re_sum = ac_x - bd_x;
            im_sum = ad_x + bc_x;
        end
    end

`ifdef CMULT_SAT_EN
    assign re_p3_d = sat_w(round_q(re_sum));
    assign im_p3_d = sat_w(round_q(im_sum));
`else
    assign re_p3_d = re_sum;
    assign im_p3_d = im_sum;
`endif

    always_ff @(posedge Clk) begin
        if (adv3 && vld_p2_q) begin
            re_p3_q <= re_p3_d;
            im_p3_q <= im_p3_d;
        end
    end

    // ---- S3 -> output -------------------------------------------------------
    // The data registers are not reset. The output is masked with the valid
    // bit, so it reads 0 whenever no result is presented, including straight
    // after reset.
    assign OutValid = vld_p3_q;
    assign OutP     = vld_p3_q ? {re_p3_q, im_p3_q} : '0;

endmodule

// File: tb/tb_complex_mult_pipe.sv
`timescale 1ns/1ps
module tb_complex_mult_pipe;

    localparam int W = 8;
`ifdef CMULT_SAT_EN
    localparam int OUT_W = W;
`else
    localparam int OUT_W = 2 * W + 1;
`endif

    logic                 Clk;
    logic                 Reset_n;
    logic                 InValid;
    logic                 InReady;
    logic [2*W-1:0]       InA;
    logic [2*W-1:0]       InB;
    logic                 InConj;
    logic                 OutValid;
    logic                 OutReady;
    logic [2*OUT_W-1:0]   OutP;

    complex_mult_pipe #(.W(W)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .InA      (InA),
        .InB      (InB),
        .InConj   (InConj),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutP     (OutP)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_in     = 0;
    int n_out    = 0;
    bit done     = 0;

    logic [2*OUT_W-1:0] exp_q[$];
    logic               stall_prev;
    logic [2*OUT_W-1:0] held_p;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [2*OUT_W-1:0] pack(input int re, input int im);
        return {OUT_W'(re), OUT_W'(im)};
    endfunction

`ifdef CMULT_SAT_EN
    function automatic int rescale(input int x);
        int r;
        r = (x + (1 << (W - 2))) >>> (W - 1);
        if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
        if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
        return r;
    endfunction
`endif

    // Reference: integer complex product from the raw operand words.
    function automatic logic [2*OUT_W-1:0] model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                                 input logic cj);
        int ar, ai, br, bi, re, im;
        ar = int'($signed(a[2*W-1:W]));
        ai = int'($signed(a[W-1:0]));
        br = int'($signed(b[2*W-1:W]));
        bi = int'($signed(b[W-1:0]));
        if (cj) begin
            re = ar * br + ai * bi;
            im = ai * br - ar * bi;
        end else begin
            re = ar * br - ai * bi;
            im = ar * bi + ai * br;
        end
`ifdef CMULT_SAT_EN
        re = rescale(re);
        im = rescale(im);
`endif
        return pack(re, im);
    endfunction

    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial begin
        stall_prev = 1'b0;
        held_p     = '0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_hold_p", 64'(OutP), 64'(held_p));
                    check_eq("stall_hold_valid", 64'(OutValid), 64'(1));
                end
                check_eq("in_ready", 64'(InReady), 64'(!(exp_q.size() == 3 && !OutReady)));
                if (OutValid && OutReady) begin
                    check_eq("out_pending", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        check_eq("out_data", 64'(OutP), 64'(exp_q.pop_front()));
                        n_out++;
                    end
                end
                if (InValid && InReady) begin
                    exp_q.push_back(model(InA, InB, InConj));
                    n_in++;
                end
                stall_prev = OutValid && !OutReady;
                held_p     = OutP;
            end
        end
    end

    task automatic send(input logic signed [W-1:0] ar, ai, br, bi, input logic cj);
        logic took;
        int   g;
        took = 1'b0;
        g    = 0;
        InA = {ar, ai};
        InB = {br, bi};
        InConj = cj;
        InValid = 1'b1;
        while (!took && g < 200) begin
            @(negedge Clk);
            took = InReady;
            @(posedge Clk);
            #1;
            g++;
        end
        InValid = 1'b0;
        check_eq("send_accept", 64'(took), 64'(1));
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge Clk);
            #1;
            g++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, out0, acc, seen;
        logic rdy;
        logic [2*OUT_W-1:0] e_basic, e_conj, e_corner;

`ifdef CMULT_SAT_EN
        e_basic  = pack(0, 0);
        e_conj   = pack(0, 0);
        e_corner = pack(0, 127);
`else
        e_basic  = pack(-2, 23);
        e_conj   = pack(-22, -7);
        e_corner = pack(0, 32768);
`endif

        Reset_n  = 1'b0;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        InConj   = 1'b0;
        OutReady = 1'b1;
        wait_cycles(3);
        check_eq("rst_out_valid", 64'(OutValid), 64'(0));
        check_eq("rst_out_p", 64'(OutP), 64'(0));
        Reset_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(InReady), 64'(1));
        wait_cycles(2);

        // Basic product with latency check
        send(W'(3), W'(-2), W'(-4), W'(5), 1'b0);
        check_eq("basic_lat1", 64'(OutValid), 64'(0));
        wait_cycles(1);
        check_eq("basic_lat2", 64'(OutValid), 64'(0));
        wait_cycles(1);
        check_eq("basic_valid", 64'(OutValid), 64'(1));
        check_eq("basic_p", 64'(OutP), 64'(e_basic));

        // Conjugate product
        send(W'(3), W'(-2), W'(-4), W'(5), 1'b1);
        wait_cycles(2);
        check_eq("conj_valid", 64'(OutValid), 64'(1));
        check_eq("conj_p", 64'(OutP), 64'(e_conj));

        // Most-negative corner: needs the 2W+1-th bit
        send(W'(-128), W'(-128), W'(-128), W'(-128), 1'b0);
        wait_cycles(2);
        check_eq("corner_valid", 64'(OutValid), 64'(1));
        check_eq("corner_p", 64'(OutP), 64'(e_corner));
        wait_drain();

        // Streaming: 100 back-to-back samples, one per clock
        out0 = n_out;
        t0   = cyc;
        for (int i = 0; i < 100; i++) begin
            send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        end
        check_eq("stream_rate", 64'(cyc - t0), 64'(100));
        wait_drain();
        check_eq("stream_count", 64'(n_out - out0), 64'(100));

        // Random backpressure and random input gaps
        out0 = n_out;
        done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
                    if ($urandom_range(0, 1) == 1) wait_cycles(1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge Clk);
                    #1;
                    OutReady = 1'($urandom_range(0, 1));
                end
            end
        join
        OutReady = 1'b1;
        wait_drain();
        check_eq("bp_count", 64'(n_out - out0), 64'(150));

        // Full stall: exactly three samples fit
        out0 = n_out;
        OutReady = 1'b0;
        acc = 0;
        InA = {W'(1), W'(0)};
        InB = {W'(7), W'(2)};
        InConj = 1'b0;
        InValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            rdy = InReady;
            @(posedge Clk);
            #1;
            if (rdy) begin
                acc++;
                InA = {W'(acc * 3 + 1), W'(-acc * 5)};
                InB = {W'(acc + 7), W'(2 - acc)};
                InConj = 1'(acc);
            end
        end
        check_eq("stall_accept", 64'(acc), 64'(3));
        OutReady = 1'b1;
        @(negedge Clk);
        check_eq("release_in_ready", 64'(InReady), 64'(1));
        check_eq("release_out_valid", 64'(OutValid), 64'(1));
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        wait_drain();
        check_eq("release_count", 64'(n_out - out0), 64'(4));

        // Mid-stream reset flushes in-flight samples
        OutReady = 1'b0;
        send(W'(10), W'(20), W'(30), W'(40), 1'b0);
        send(W'(-5), W'(6), W'(7), W'(-8), 1'b1);
        wait_cycles(1);
        check_eq("pre_rst_valid", 64'(OutValid), 64'(1));
        #1;
        Reset_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(OutValid), 64'(0));
        check_eq("mid_rst_out_p", 64'(OutP), 64'(0));
        wait_cycles(2);
        Reset_n = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", 64'(InReady), 64'(1));
        OutReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (OutValid) seen++;
        end
        check_eq("no_stale_result", 64'(seen), 64'(0));
        check_eq("post_rst_out_p", 64'(OutP), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
